// File: rtl/myo_frame_controller.sv
// SPI frame sequencer between spi_slave and the MyoControlInterface bank.
// Validates host frames, commits parameter words and streams status bytes.
//
// Ports:
//   clock, reset         system clock, async active-high reset
//   frame_n              host frame select (async, active low)
//   rx_valid, rx_data    received byte stream from the SPI slave
//   tx_data, tx_wren     transmit byte and load strobe to the SPI slave
//   status_addr/_data    status word read for the selected motor
//   motor_sel            motor of the last committed frame
//   param_we/addr/data   parameter bank write port
//   frame_ok, frame_err  commit / reject pulses
//   err_count            saturating rejected-frame counter
//
// Build option: define MYO_FRAME_CHECKSUM_EN to verify the XOR checksum.
module myo_frame_controller #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int FRAME_BYTES      = 37
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    output logic        tx_wren,
    output logic [3:0]  status_addr,
    input  logic [31:0] status_data,
    output logic [7:0]  motor_sel,
    output logic        param_we,
    output logic [3:0]  param_addr,
    output logic [31:0] param_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] err_count
);

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] FB = CW'(FRAME_BYTES);
    localparam logic [7:0] NM = 8'(NUMBER_OF_MOTORS);
    localparam logic [3:0] LAST_WORD = 4'd10;
`ifdef MYO_FRAME_CHECKSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RECEIVE, CHECK, COMMIT} state_t;

    state_t state_q, state_d;

    logic fn_s1_q, fn_s2_q, fn_s3_q, rx_prev_q;
    logic fn_fall, fn_rise, rx_rise;

    logic [CW-1:0] cnt_q, cnt_d, tx_idx_q, tx_idx_d;
    logic [7:0]    acc_q, acc_d;
    logic          ovr_q, ovr_d, late_q, late_d;
    logic [7:0]    rx_buf_q [FRAME_BYTES];
    logic [7:0]    rx_buf_d [FRAME_BYTES];
    logic [3:0]    word_q, word_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wren_q, tx_wren_d;
    logic [7:0]    motor_sel_q, motor_sel_d;
    logic [15:0]   err_q, err_d;

    logic          pass;
    logic [7:0]    tx_byte;
    logic [5:0]    base;
    logic [31:0]   word_w;

    // frame_n: two sync flops plus a history flop for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fn_s1_q   <= 1'b1;
            fn_s2_q   <= 1'b1;
            fn_s3_q   <= 1'b1;
            rx_prev_q <= 1'b0;
        end else begin
            fn_s1_q   <= frame_n;
            fn_s2_q   <= fn_s1_q;
            fn_s3_q   <= fn_s2_q;
            rx_prev_q <= rx_valid;
        end
    end

    assign fn_fall = fn_s3_q & ~fn_s2_q;
    assign fn_rise = ~fn_s3_q & fn_s2_q;
    assign rx_rise = rx_valid & ~rx_prev_q;

    // tx_idx_q always names the next byte to load, so status_addr is
    // already pointing at its word when the load happens
    assign tx_byte = status_data[{tx_idx_q[1:0], 3'b000} +: 8];

    assign pass = (cnt_q == FB)
                & (~CSUM_EN | (acc_q == 8'h00))
                & (rx_buf_q[0] < NM)
                & ~ovr_q
                & ~late_q;

    // Words 0-4 start at byte 4w+1, words 7-9 at byte 4w-4
    assign base = (word_q < 4'd5) ? {word_q, 2'b01}
                                  : {word_q - 4'd1, 2'b00};

    always_comb begin
        unique case (word_q)
            4'd5:    word_w = {24'h0, rx_buf_q[21]};
            4'd6:    word_w = {16'h0, rx_buf_q[23], rx_buf_q[22]};
            default: word_w = {rx_buf_q[base + 6'd3], rx_buf_q[base + 6'd2],
                               rx_buf_q[base + 6'd1], rx_buf_q[base]};
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fn_fall || late_q) state_d = RECEIVE;
            RECEIVE: if (fn_rise) state_d = CHECK;
            CHECK:   state_d = pass ? COMMIT : IDLE;
            COMMIT:  if (word_q == LAST_WORD) state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        param_we   = 1'b0;
        param_addr = 4'h0;
        param_data = 32'h0;
        frame_ok   = 1'b0;
        frame_err  = 1'b0;
        unique case (state_q)
            CHECK:  frame_err = ~pass;
            COMMIT: begin
                if (word_q == LAST_WORD) begin
                    frame_ok = 1'b1;
                end else begin
                    param_we   = 1'b1;
                    param_addr = word_q;
                    param_data = word_w;
                end
            end
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovr_d       = ovr_q;
        late_d      = late_q;
        rx_buf_d    = rx_buf_q;
        word_d      = word_q;
        tx_idx_d    = tx_idx_q;
        tx_data_d   = tx_data_q;
        tx_wren_d   = 1'b0;
        motor_sel_d = motor_sel_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                // a start latched during CHECK/COMMIT keeps late set
                if (fn_fall || late_q) begin
                    cnt_d     = '0;
                    acc_d     = 8'h00;
                    ovr_d     = 1'b0;
                    tx_wren_d = 1'b1;
                    tx_data_d = tx_byte;
                    tx_idx_d  = CW'(1);
                end
            end
            RECEIVE: begin
                if (rx_rise) begin
                    tx_wren_d = 1'b1;
                    if (tx_idx_q < FB) begin
                        tx_data_d = tx_byte;
                        tx_idx_d  = tx_idx_q + CW'(1);
                    end else begin
                        tx_data_d = 8'h00;
                    end
                    if (cnt_q < FB) begin
                        rx_buf_d[cnt_q] = rx_data;
                        acc_d           = acc_q ^ rx_data;
                        cnt_d           = cnt_q + CW'(1);
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                tx_idx_d = '0;
                word_d   = 4'h0;
                late_d   = fn_fall;
                if (pass)                  motor_sel_d = rx_buf_q[0];
                else if (err_q != 16'hFFFF) err_d       = err_q + 16'd1;
            end
            COMMIT: begin
                word_d = word_q + 4'd1;
                if (fn_fall) late_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= 8'h00;
            ovr_q       <= 1'b0;
            late_q      <= 1'b0;
            word_q      <= 4'h0;
            tx_idx_q    <= '0;
            tx_data_q   <= 8'h00;
            tx_wren_q   <= 1'b0;
            motor_sel_q <= 8'h00;
            err_q       <= 16'h0;
            for (int i = 0; i < FRAME_BYTES; i++) rx_buf_q[i] <= 8'h00;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovr_q       <= ovr_d;
            late_q      <= late_d;
            word_q      <= word_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            tx_wren_q   <= tx_wren_d;
            motor_sel_q <= motor_sel_d;
            err_q       <= err_d;
            rx_buf_q    <= rx_buf_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_wren     = tx_wren_q;
    assign status_addr = tx_idx_q[5:2];
    assign motor_sel   = motor_sel_q;
    assign err_count   = err_q;

endmodule

// File: doc/myo_frame_controller.md
# myo_frame_controller

Sequences the byte-level SPI link between the SAMD host and the motor control core. It consumes the received byte stream from the SPI slave and validates each frame's length, motor index and checksum. It commits a valid frame's parameter words into the per-motor parameter bank, one word per cycle, and feeds the slave's transmit path with status bytes of the last-commanded motor. It sits between `spi_slave` and the `MyoControlInterface` register bank, on the 24 MHz system clock.

## Interface
- `NUMBER_OF_MOTORS`, 6: motors addressable; motor index byte must be below this.
- `FRAME_BYTES`, 37: bytes per frame, including the trailing checksum byte.
- `clock`  in  1  system clock (24 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `frame_n`  in  1  host frame select, active low, asynchronous; synchronized internally.
- `rx_valid`  in  1  slave `do_valid_o` level, same clock domain; block edge-detects it.
- `rx_data`  in  8  slave `do_o`.
- `tx_data`  out  8  byte presented to slave `di_i`.
- `tx_wren`  out  1  one-cycle load strobe to slave `wren_i`.
- `status_addr`  out  4  word index into the status bank of `motor_sel`.
- `status_data`  in  32  combinational read of `status_addr`.
- `motor_sel`  out  8  motor of the last committed frame.
- `param_we`  out  1  parameter word write strobe.
- `param_addr`  out  4  parameter word index 0..9.
- `param_data`  out  32  parameter word.
- `frame_ok`  out  1  one-cycle pulse after a successful commit.
- `frame_err`  out  1  one-cycle pulse on a rejected frame.
- `err_count`  out  16  rejected-frame counter, saturating at 0xFFFF.

## Operation
- Frame layout, little-endian:
  - byte 0: motor index.
  - bytes 1-20: Kp, Ki, Kd, sp, outputLimit (words 0-4).
  - byte 21: control_mode (word 5, zero-extended).
  - bytes 22-23: controlFlags (word 6, zero-extended).
  - bytes 24-35: update_frequency, pos/dis encoder multipliers (words 7-9).
  - byte 36: checksum, the XOR of bytes 0-35; the XOR over the whole frame must be 0x00.
- States: IDLE, RECEIVE, CHECK, COMMIT.
- IDLE:
  - On a synchronized falling edge of `frame_n`: clear byte counter, XOR accumulator and overrun flag, pulse `tx_wren` with tx byte 0, go to RECEIVE.
- RECEIVE:
  - Each `rx_valid` rising edge with counter < FRAME_BYTES: store the byte, XOR it into the accumulator, increment the counter, pulse `tx_wren` with tx byte counter+1.
  - An edge at counter ≥ FRAME_BYTES sets overrun; `tx_data` is 0x00.
  - A synchronized rising edge of `frame_n` goes to CHECK.
- CHECK (1 cycle): the frame passes only if all of these hold:
  - counter == FRAME_BYTES;
  - accumulator == 0;
  - byte 0 < NUMBER_OF_MOTORS;
  - no overrun and no late flag.
  - Pass goes to COMMIT. Fail pulses `frame_err`, increments `err_count` (saturating), goes to IDLE; `motor_sel` and the bank are unchanged.
- COMMIT:
  - Latch `motor_sel` = byte 0.
  - Assert `param_we` for 10 consecutive cycles, `param_addr` 0..9 with the corresponding word.
  - Then pulse `frame_ok` and go to IDLE.
- TX byte k (k < FRAME_BYTES): `status_addr` = k[5:2], `tx_data` = byte k[1:0] of `status_data`, for the current `motor_sel`.
- Frame start during CHECK/COMMIT:
  - The falling edge is latched and sets the late flag.
  - On entering IDLE the block goes directly to RECEIVE; that frame fails CHECK.
- `frame_n` rising while in IDLE is ignored.

## Timing
- Reset values:
  - all strobes 0, `tx_data` 0x00, `status_addr` 0, `motor_sel` 0;
  - `param_addr` 0, `param_data` 0, `err_count` 0, state IDLE.
- `reset` mid-frame aborts immediately; the bank is not written further and `err_count` is not incremented.
- `frame_n` passes a 2-flop synchronizer plus an edge register: 3 cycles from pin edge to state change.
- `rx_valid` rise to `tx_wren`: 1 cycle. `tx_data` is valid in the `tx_wren` cycle.
- Frame end (synchronized) to CHECK: 1 cycle. The first `param_we` follows CHECK in the next cycle.
- `frame_ok` comes 1 cycle after the last `param_we`. Commit total: 12 cycles after CHECK entry.
- `rx_valid` edge and `frame_n` rising edge in the same cycle: the byte is counted first, then CHECK is entered.

## Configuration
- `MYO_FRAME_CHECKSUM_EN` defined: the checksum is verified in CHECK as above.
- Undefined: the checksum byte is still received and counted but the XOR test is skipped; length, index and overrun checks remain.

## Test plan
- Valid frame, motor 2, Kp=0x3F800000, checksum correct:
  - 10 `param_we` cycles, word 0 = 0x3F800000;
  - `motor_sel`=2, one `frame_ok`, `err_count`=0.
- Same frame with byte 5 flipped:
  - `frame_err` pulse, `err_count`=1, no `param_we`.
  - With the macro undefined: commit occurs instead.
- Motor index 6 with NUMBER_OF_MOTORS=6: rejected, `err_count` increments, `motor_sel` unchanged.
- Length errors:
  - 36 bytes: rejected.
  - 38 bytes: overrun, 38th `tx_data`=0x00, rejected.
- Status readback:
  - `status_data` word 1 = 0xAABBCCDD; bytes 4-7 sent: DD, CC, BB, AA, each loaded 1 cycle after the previous `rx_valid` rise.
- Reset and late start:
  - `reset` asserted at byte 20: outputs return to reset values immediately.
  - New frame after reset: accepted.
  - Frame start during COMMIT: that frame is rejected.
